// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: shared definitions for the EX/MEM pipeline stage.
//   - ctrl bit indices and width of the 7-bit control bundle
//     {reg_write, mem_to_reg, branch, zero, is_greater, mem_write, mem_read}
//   - branch funct3 codes
//   - payload struct for the default configuration
//   - branch_taken(): branch resolution evaluated when an entry is loaded
package ex_mem_pkg;

  localparam int CTRL_W          = 7;
  localparam int CTRL_REG_WRITE  = 6;
  localparam int CTRL_MEM_TO_REG = 5;
  localparam int CTRL_BRANCH     = 4;
  localparam int CTRL_ZERO       = 3;
  localparam int CTRL_IS_GREATER = 2;
  localparam int CTRL_MEM_WRITE  = 1;
  localparam int CTRL_MEM_READ   = 0;

  localparam logic [2:0] BR_EQ = 3'b000;
  localparam logic [2:0] BR_NE = 3'b001;
  localparam logic [2:0] BR_LT = 3'b100;
  localparam logic [2:0] BR_GE = 3'b101;

  localparam int PKG_XLEN       = 64;
  localparam int PKG_REG_ADDR_W = 5;
  localparam int PKG_FUNCT_W    = 4;

  // Payload layout for the default widths; the stage builds an identical
  // layout from its own parameters so non-default widths also work.
  typedef struct packed {
    logic                      branch_taken;
    logic [CTRL_W-1:0]         ctrl;
    logic [PKG_XLEN-1:0]       branch_target;
    logic [PKG_XLEN-1:0]       alu_result;
    logic [PKG_XLEN-1:0]       write_data;
    logic [PKG_FUNCT_W-1:0]    funct;
    logic [PKG_REG_ADDR_W-1:0] dest_reg;
  } ex_mem_payload_t;

  // LT/GE use the ALU flags directly: "less" means neither greater nor equal.
  function automatic logic branch_taken(input logic       branch,
                                        input logic       zero,
                                        input logic       is_greater,
                                        input logic [2:0] funct3);
    logic cond;
    case (funct3)
      BR_EQ:   cond = zero;
      BR_NE:   cond = !zero;
      BR_LT:   cond = !is_greater && !zero;
      BR_GE:   cond = is_greater || zero;
      default: cond = 1'b0;
    endcase
    return branch && cond;
  endfunction

endpackage

// File: rtl/ex_mem_slot.sv
// ex_mem_slot: one valid bit plus payload register.
//   clk, rst_n     : clock, synchronous active-low reset
//   load           : capture d_valid/d_data this edge
//   clear          : empty the slot (wins over load)
//   d_valid,d_data : value to load; an invalid load stores a zero payload
//   q_valid,q_data : registered slot contents
module ex_mem_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clear,
  input  logic         d_valid,
  input  logic [W-1:0] d_data,
  output logic         q_valid,
  output logic [W-1:0] q_data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = 1'b0;
      data_d  = '0;
    end else if (load) begin
      valid_d = d_valid;
      // Keep empty slots at zero so held payload never leaks stale values.
      data_d  = d_valid ? d_data : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign q_valid = valid_q;
  assign q_data  = data_q;

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register with a 2-entry skid buffer.
//   Input side  : in_valid/in_ready plus ctrl, branch target, ALU result,
//                 store data, funct, destination register.
//   Output side : out_valid/out_ready plus the held payload and the
//                 registered branch decision out_branch_taken.
//   flush       : squashes both held entries and any beat offered that cycle.
// Optional feature macro EX_MEM_PERF_EN adds perf_stall_cnt and
// perf_flush_cnt (saturating 32-bit counters).
//
// Handshake: a beat transfers on a clock edge where valid && ready are both
// high. The sender holds its beat stable until it transfers; in_ready depends
// only on registered state (skid slot empty), never on out_ready.
module ex_mem_stage
  import ex_mem_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5,
  parameter int FUNCT_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_W-1:0]     in_ctrl,
  input  logic [XLEN-1:0]       in_branch_target,
  input  logic [XLEN-1:0]       in_alu_result,
  input  logic [XLEN-1:0]       in_write_data,
  input  logic [FUNCT_W-1:0]    in_funct,
  input  logic [REG_ADDR_W-1:0] in_dest_reg,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_W-1:0]     out_ctrl,
  output logic [XLEN-1:0]       out_branch_target,
  output logic [XLEN-1:0]       out_alu_result,
  output logic [XLEN-1:0]       out_write_data,
  output logic [FUNCT_W-1:0]    out_funct,
  output logic [REG_ADDR_W-1:0] out_dest_reg,
  output logic                  out_branch_taken
`ifdef EX_MEM_PERF_EN
  ,
  output logic [31:0]           perf_stall_cnt,
  output logic [31:0]           perf_flush_cnt
`endif
);

  typedef struct packed {
    logic                  branch_taken;
    logic [CTRL_W-1:0]     ctrl;
    logic [XLEN-1:0]       branch_target;
    logic [XLEN-1:0]       alu_result;
    logic [XLEN-1:0]       write_data;
    logic [FUNCT_W-1:0]    funct;
    logic [REG_ADDR_W-1:0] dest_reg;
  } payload_t;

  localparam int PAYLOAD_W = $bits(payload_t);

  payload_t in_pl;
  payload_t main_pl, skid_pl;
  payload_t main_d_data, skid_d_data;
  logic     main_valid, skid_valid;
  logic     main_load, main_clear, main_d_valid;
  logic     skid_load, skid_clear, skid_d_valid;
  logic     accept, drain;

  // Branch decision is resolved once, on entry, and travels with the beat.
  always_comb begin
    in_pl.branch_taken  = branch_taken(in_ctrl[CTRL_BRANCH], in_ctrl[CTRL_ZERO],
                                       in_ctrl[CTRL_IS_GREATER], in_funct[2:0]);
    in_pl.ctrl          = in_ctrl;
    in_pl.branch_target = in_branch_target;
    in_pl.alu_result    = in_alu_result;
    in_pl.write_data    = in_write_data;
    in_pl.funct         = in_funct;
    in_pl.dest_reg      = in_dest_reg;
  end

  assign in_ready = !skid_valid;
  assign accept   = in_valid && in_ready;
  assign drain    = main_valid && out_ready;

  always_comb begin
    main_load    = 1'b0;
    main_clear   = 1'b0;
    main_d_valid = 1'b0;
    main_d_data  = in_pl;
    skid_load    = 1'b0;
    skid_clear   = 1'b0;
    skid_d_valid = 1'b0;
    skid_d_data  = in_pl;
    if (flush) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else if (!main_valid || drain) begin
      main_load = 1'b1;
      if (skid_valid) begin
        // Oldest beat moves forward; a new beat (if any) refills the skid.
        main_d_valid = 1'b1;
        main_d_data  = skid_pl;
        skid_load    = 1'b1;
        skid_d_valid = accept;
      end else begin
        main_d_valid = accept;
      end
    end else if (accept) begin
      // Main is stalled: park the beat so EX is not stalled combinationally.
      skid_load    = 1'b1;
      skid_d_valid = 1'b1;
    end
  end

  ex_mem_slot #(.W(PAYLOAD_W)) u_main (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (main_load),
    .clear   (main_clear),
    .d_valid (main_d_valid),
    .d_data  (main_d_data),
    .q_valid (main_valid),
    .q_data  (main_pl)
  );

  ex_mem_slot #(.W(PAYLOAD_W)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (skid_load),
    .clear   (skid_clear),
    .d_valid (skid_d_valid),
    .d_data  (skid_d_data),
    .q_valid (skid_valid),
    .q_data  (skid_pl)
  );

  // Side-effecting control bits must never assert without a valid beat.
  always_comb begin
    out_ctrl                 = main_pl.ctrl;
    out_ctrl[CTRL_REG_WRITE] = main_pl.ctrl[CTRL_REG_WRITE] && main_valid;
    out_ctrl[CTRL_MEM_WRITE] = main_pl.ctrl[CTRL_MEM_WRITE] && main_valid;
    out_ctrl[CTRL_MEM_READ]  = main_pl.ctrl[CTRL_MEM_READ]  && main_valid;
  end

  assign out_valid         = main_valid;
  assign out_branch_target = main_pl.branch_target;
  assign out_alu_result    = main_pl.alu_result;
  assign out_write_data    = main_pl.write_data;
  assign out_funct         = main_pl.funct;
  assign out_dest_reg      = main_pl.dest_reg;
  assign out_branch_taken  = main_pl.branch_taken && main_valid;

`ifdef EX_MEM_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (main_valid && !out_ready && stall_cnt_q != 32'hFFFF_FFFF) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (flush && (main_valid || skid_valid) && flush_cnt_q != 32'hFFFF_FFFF) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Parametrised EX/MEM pipeline stage register with a valid/ready handshake, a 2-entry skid buffer, flush, and registered branch resolution.
- Sits between the ALU (EX) and data memory (MEM).
- Replaces the single always-load EX/MEM latch so that MEM-side stalls (cache miss) no longer drop or duplicate instructions.

Parameters:
XLEN, 64, datapath width (ALU result, store data, branch target)
REG_ADDR_W, 5, destination register index width
FUNCT_W, 4, function code width; bits [2:0] carry branch funct3

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
flush  input  1  squash all held and incoming entries
in_valid  input  1  EX presents a valid beat
in_ready  output  1  stage can accept a beat
in_ctrl  input  7  {reg_write, mem_to_reg, branch, zero, is_greater, mem_write, mem_read}, bit 6 down to 0
in_branch_target  input  XLEN  PC + immediate
in_alu_result  input  XLEN  ALU result
in_write_data  input  XLEN  store data
in_funct  input  FUNCT_W  function code
in_dest_reg  input  REG_ADDR_W  destination register
out_valid  output  1  MEM-side beat valid
out_ready  input  1  MEM consumes the beat
out_ctrl  output  7  same bit map as in_ctrl; bits reg_write, mem_write, mem_read forced 0 when out_valid=0
out_branch_target, out_alu_result, out_write_data  output  XLEN  held payload
out_funct  output  FUNCT_W  held payload
out_dest_reg  output  REG_ADDR_W  held payload
out_branch_taken  output  1  registered branch decision, 0 when out_valid=0

Behaviour:
- One clock domain (clk). Reset is synchronous and active-low (rst_n); polarity and synchronicity are fixed.
- Reset (rst_n=0 at a clk edge):
  - main and skid valid bits cleared.
  - All payload and out_* ports zero; out_branch_taken=0.
  - in_ready=1 from the first cycle after reset.
- State: main slot (drives out_*) and skid slot. in_ready = !skid_valid (registered, no combinational path from out_ready).
- accept = in_valid & in_ready; drain = out_valid & out_ready.
- Per-edge priority:
  1. flush: both valids cleared, payload zeroed, accepted beat dropped; in_ready=1 next cycle.
  2. main empty or drain:
     - if skid valid: main <= skid, skid <= accepted beat (if accept), else skid cleared.
     - else: main <= accepted beat, or main empty if no accept.
  3. main full, no drain, accept: beat written to skid; in_ready drops next cycle.
- Latency: 1 cycle from accept to out_valid when the stage is empty. Throughput 1 beat/cycle with out_ready held high.
- No beat is lost or duplicated under any in_valid/out_ready pattern. Order is preserved (FIFO).
- Branch decision is computed at slot load from ctrl.branch, zero, is_greater and funct[2:0]:
  - 000 → zero
  - 001 → !zero
  - 100 → !is_greater & !zero
  - 101 → is_greater | zero
  - any other code → 0
  - The result is stored with the entry and moves with it from skid to main.
- flush together with drain in the same cycle: the drained beat counts as consumed; nothing else survives.
- in_valid while in_ready=0: ignored; EX must hold its beat.

Optional Feature:
EX_MEM_PERF_EN:
- Defined: adds outputs perf_stall_cnt [31:0] and perf_flush_cnt [31:0].
  - perf_stall_cnt increments each cycle with out_valid & !out_ready.
  - perf_flush_cnt increments per cycle with flush=1 while any slot is valid.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package ex_mem_pkg:
  - ctrl bit index constants (CTRL_REG_WRITE=6 … CTRL_MEM_READ=0) and CTRL_W=7.
  - Branch funct3 codes (BR_EQ, BR_NE, BR_LT, BR_GE).
  - A payload struct typedef, parametrised through localparam widths.
  - A branch_taken function.
- Sub-module ex_mem_slot: one valid+payload register with load, clear, and synchronous reset. It is instantiated twice (main, skid).

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 → out_valid=0, out_ctrl=0, in_ready=1; first beat accepted the cycle after release.
- Streaming: out_ready=1, 4 beats with ALU results 0x10,0x20,0x30,0x40 on consecutive cycles → same values on out_alu_result on cycles 1–4; in_ready stays 1.
- Backpressure: out_ready=0, send beats A=0x11 and B=0x22 → in_ready=0 after B; raise out_ready → A then B emitted in order, no duplicates.
- Flush: both slots full, flush=1 with in_valid=1 (beat 0x33) → next cycle out_valid=0, in_ready=1, 0x33 never appears.
- Branch: funct=0001, branch=1, zero=0 → out_branch_taken=1; funct=0101, is_greater=0, zero=0 → 0; funct=0011 → 0.
- With EX_MEM_PERF_EN: 5 stall cycles plus 1 flush with a valid slot → perf_stall_cnt=5, perf_flush_cnt=1.
